i2c_pkt_arbiter: RTL

- Shares one I2C controller among REQ_N requesters (CPU bridge, sensor-init sequencer, PMIC poller).
- Takes byte-stream packets in the I2C controller's TX packet format (address byte(s), then data bytes or a final read-count byte). Arbitrates round-robin with packet granularity and writes the winning packet into the controller's TX FIFO.
- Records the originator and byte count of every read packet in an internal tag FIFO. Uses those tags to route bytes from the controller's RX FIFO back to the correct requester.

---
 rtl/i2c_pkt_arbiter_if.sv | 36 +++
 rtl/i2c_pkt_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_pkt_arbiter_if.sv
// i2c_pkt_arbiter_if
// Groups the handshake and FIFO buses around the I2C packet arbiter.
//   s_pkt_*      : byte-stream packets from REQ_N requesters (valid/ready, last)
//   tx_fifo_*    : write side of the I2C controller TX FIFO
//   rx_fifo_*    : read side of the I2C controller RX FIFO (dout valid the cycle after ren)
//   m_rx_*       : received bytes routed back to requesters (one-cycle pulses)
// Modport slave is the arbiter's view; modport master is the environment's view.
interface i2c_pkt_arbiter_if #(
  parameter int REQ_N = 2
);
  logic [REQ_N-1:0]   s_pkt_valid;
  logic [8*REQ_N-1:0] s_pkt_data;
  logic [REQ_N-1:0]   s_pkt_last;
  logic [REQ_N-1:0]   s_pkt_ready;
  logic               tx_fifo_wen;
  logic               tx_fifo_full;
  logic [7:0]         tx_fifo_din;
  logic               tx_fifo_din_last;
  logic               rx_fifo_ren;
  logic               rx_fifo_empty;
  logic [7:0]         rx_fifo_dout;
  logic [REQ_N-1:0]   m_rx_valid;
  logic [7:0]         m_rx_data;

  modport slave (
    input  s_pkt_valid, s_pkt_data, s_pkt_last, tx_fifo_full, rx_fifo_empty, rx_fifo_dout,
    output s_pkt_ready, tx_fifo_wen, tx_fifo_din, tx_fifo_din_last, rx_fifo_ren,
           m_rx_valid, m_rx_data
  );

  modport master (
    output s_pkt_valid, s_pkt_data, s_pkt_last, tx_fifo_full, rx_fifo_empty, rx_fifo_dout,
    input  s_pkt_ready, tx_fifo_wen, tx_fifo_din, tx_fifo_din_last, rx_fifo_ren,
           m_rx_valid, m_rx_data
  );
endinterface

// File: rtl/i2c_pkt_arbiter.sv
// i2c_pkt_arbiter
// Shares one I2C controller among REQ_N requesters. Whole packets are granted
// round-robin and streamed into the controller TX FIFO. Every read packet
// leaves a {requester, byte count} tag; the tags steer RX FIFO bytes back to
// the requester that asked for them.
// Ports:
//   clk        : clock
//   resetn     : asynchronous active-low reset
//   bus        : i2c_pkt_arbiter_if.slave (requester, TX FIFO, RX FIFO, return buses)
//   grant_id_o : currently / last granted requester
//   busy_o     : packet in flight, read tags outstanding, or RX transfer active
module i2c_pkt_arbiter #(
  parameter int REQ_N     = 2,
  parameter int TAG_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  i2c_pkt_arbiter_if.slave        bus,
  output logic [1:0]              grant_id_o,
  output logic                    busy_o
);

  localparam int AW = $clog2(TAG_DEPTH);

  localparam logic [0:0] A_IDLE = 1'b0;
  localparam logic [0:0] A_FWD  = 1'b1;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_REQ  = 2'd1;
  localparam logic [1:0] R_CAP  = 2'd2;

  logic [0:0]       aState_q, aState_d;
  logic [1:0]       grant_q, grant_d;
  logic [1:0]       rrPtr_q, rrPtr_d;
  logic             firstByte_q, firstByte_d;
  logic             isRd_q, isRd_d;

  logic [1:0]       rState_q, rState_d;
  logic [3:0]       rem_q, rem_d;
  logic [1:0]       rxId_q, rxId_d;
  logic [REQ_N-1:0] rxValid_q;
  logic [7:0]       rxData_q;

  logic [5:0]       tagMem_q [TAG_DEPTH];
  logic [AW-1:0]    wrPtr_q, rdPtr_q;
  logic [AW:0]      tagCnt_q;

  logic             found;
  logic [1:0]       winner;
  logic             selValid, selLast;
  logic [7:0]       selData;
  logic             fwd, xfer, effRd, tagPush, tagPop, tagFull, tagEmpty, ren;
  logic [1:0]       nextPtr;
  logic [5:0]       tagHead;

  // Round-robin search: the lowest valid index at or above rrPtr wins,
  // otherwise the lowest valid index below it (the wrapped part of the ring).
  always_comb begin
    found  = 1'b0;
    winner = 2'd0;
    for (int i = REQ_N - 1; i >= 0; i--) begin
      if (bus.s_pkt_valid[i] && (2'(i) < rrPtr_q)) begin
        found  = 1'b1;
        winner = 2'(i);
      end
    end
    for (int i = REQ_N - 1; i >= 0; i--) begin
      if (bus.s_pkt_valid[i] && (2'(i) >= rrPtr_q)) begin
        found  = 1'b1;
        winner = 2'(i);
      end
    end
  end

  always_comb begin
    selValid = 1'b0;
    selData  = 8'h00;
    selLast  = 1'b0;
    for (int i = 0; i < REQ_N; i++) begin
      if (grant_q == 2'(i)) begin
        selValid = bus.s_pkt_valid[i];
        selData  = bus.s_pkt_data[8*i +: 8];
        selLast  = bus.s_pkt_last[i];
      end
    end
  end

  assign fwd      = (aState_q == A_FWD);
  assign xfer     = fwd & selValid & ~bus.tx_fifo_full;
  // The read flag is the LSB of the first (address) byte; a one-byte packet
  // must see it on the same cycle it is written, hence the bypass.
  assign effRd    = firstByte_q ? selData[0] : isRd_q;
  assign tagPush  = xfer & selLast & effRd & (selData[3:0] != 4'd0);
  assign nextPtr  = (grant_q == 2'(REQ_N - 1)) ? 2'd0 : grant_q + 2'd1;

  assign bus.tx_fifo_wen      = xfer;
  assign bus.tx_fifo_din      = fwd ? selData : 8'h00;
  assign bus.tx_fifo_din_last = fwd & selLast;

  always_comb begin
    bus.s_pkt_ready = '0;
    for (int i = 0; i < REQ_N; i++) begin
      bus.s_pkt_ready[i] = fwd && (grant_q == 2'(i)) && !bus.tx_fifo_full;
    end
  end

  // TX FSM: a grant needs tag room so that a read packet's push always fits.
  always_comb begin
    aState_d    = aState_q;
    grant_d     = grant_q;
    rrPtr_d     = rrPtr_q;
    firstByte_d = firstByte_q;
    isRd_d      = isRd_q;
    case (aState_q)
      A_IDLE: begin
        if (found && !tagFull) begin
          grant_d     = winner;
          firstByte_d = 1'b1;
          aState_d    = A_FWD;
        end
      end
      default: begin
        if (xfer) begin
          firstByte_d = 1'b0;
          isRd_d      = effRd;
          if (selLast) begin
            rrPtr_d  = nextPtr;
            aState_d = A_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aState_q    <= A_IDLE;
      grant_q     <= 2'd0;
      rrPtr_q     <= 2'd0;
      firstByte_q <= 1'b0;
      isRd_q      <= 1'b0;
    end else begin
      aState_q    <= aState_d;
      grant_q     <= grant_d;
      rrPtr_q     <= rrPtr_d;
      firstByte_q <= firstByte_d;
      isRd_q      <= isRd_d;
    end
  end

  // Tag FIFO: entry = {requester id, outstanding byte count}.
  assign tagFull  = (tagCnt_q == (AW+1)'(TAG_DEPTH));
  assign tagEmpty = (tagCnt_q == '0);
  assign tagHead  = tagMem_q[rdPtr_q];

  always_ff @(posedge clk) begin
    if (tagPush) begin
      tagMem_q[wrPtr_q] <= {grant_q, selData[3:0]};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      tagCnt_q <= '0;
    end else begin
      if (tagPush) wrPtr_q <= wrPtr_q + AW'(1);
      if (tagPop)  rdPtr_q <= rdPtr_q + AW'(1);
      case ({tagPush, tagPop})
        2'b10:   tagCnt_q <= tagCnt_q + (AW+1)'(1);
        2'b01:   tagCnt_q <= tagCnt_q - (AW+1)'(1);
        default: tagCnt_q <= tagCnt_q;
      endcase
    end
  end

  // RX FSM: one RX FIFO read per two cycles; the tag is popped with its last byte.
  always_comb begin
    rState_d = rState_q;
    rem_d    = rem_q;
    rxId_d   = rxId_q;
    ren      = 1'b0;
    tagPop   = 1'b0;
    case (rState_q)
      R_IDLE: begin
        if (!tagEmpty) begin
          rem_d    = tagHead[3:0];
          rxId_d   = tagHead[5:4];
          rState_d = R_REQ;
        end
      end
      R_REQ: begin
        if (!bus.rx_fifo_empty) begin
          ren      = 1'b1;
          rState_d = R_CAP;
        end
      end
      R_CAP: begin
        rem_d = rem_q - 4'd1;
        if (rem_q == 4'd1) begin
          tagPop   = 1'b1;
          rState_d = R_IDLE;
        end else begin
          rState_d = R_REQ;
        end
      end
      default: rState_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rState_q  <= R_IDLE;
      rem_q     <= 4'd0;
      rxId_q    <= 2'd0;
      rxValid_q <= '0;
      rxData_q  <= 8'h00;
    end else begin
      rState_q <= rState_d;
      rem_q    <= rem_d;
      rxId_q   <= rxId_d;
      for (int i = 0; i < REQ_N; i++) begin
        rxValid_q[i] <= (rState_q == R_CAP) && (rxId_q == 2'(i));
      end
      if (rState_q == R_CAP) rxData_q <= bus.rx_fifo_dout;
    end
  end

  assign bus.rx_fifo_ren = ren;
  assign bus.m_rx_valid  = rxValid_q;
  assign bus.m_rx_data   = rxData_q;
  assign grant_id_o      = grant_q;
  assign busy_o          = fwd | ~tagEmpty | (rState_q != R_IDLE);

endmodule
